xof_parse_loader: RTL and testbench

- Upstream neighbour of the rejection-sampling parse stage in Kyber-768-90s matrix-A generation.
- Accepts the AES-256-CTR keystream (XOF output) as 128-bit beats over a valid/ready handshake.
- Unpacks each beat into bytes and fills the 768-entry buffer B that parse consumes.
- Pulses parse start once the buffer is full, waits for parse done, then reports completion.

---
 rtl/kyber_xof_pkg.sv | 33 +++
 rtl/xof_parse_loader.sv | 114 +++++++++++
 tb/tb_xof_parse_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/kyber_xof_pkg.sv
// Shared constants and loader state encoding for Kyber-768-90s matrix-A generation.
// Used by the XOF loader and the rejection-sampling parse stage.
package kyber_xof_pkg;

    localparam int unsigned NUM_BYTES  = 768;
    localparam int unsigned BEAT_BYTES = 16;
    localparam int unsigned KYBER_Q    = 3329;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned B_W        = 10;
    localparam int unsigned KS_W       = BEAT_BYTES * BYTE_W;
    localparam int unsigned BEATS      = NUM_BYTES / BEAT_BYTES;
    localparam int unsigned BEAT_CNT_W = 6;
    localparam int unsigned LANE_W     = 4;
    localparam int unsigned B_IDX_W    = BEAT_CNT_W + LANE_W;

    typedef enum logic [2:0] {
        LD_IDLE       = 3'd0,
        LD_FILL       = 3'd1,
        LD_START      = 3'd2,
        LD_WAIT_PARSE = 3'd3,
        LD_DONE       = 3'd4
    } loader_state_e;

    // Buffer address of byte lane `lane` within beat `beat` (beat*16 + lane).
    function automatic logic [B_IDX_W-1:0] b_index(
        input logic [BEAT_CNT_W-1:0] beat,
        input logic [LANE_W-1:0]     lane
    );
        return {beat, lane};
    endfunction

endpackage

// File: rtl/xof_parse_loader.sv
// Buffers 768 keystream bytes from AES-256-CTR beats into B, then hands B to
// the parse stage with a one-cycle start pulse and waits for its done level.
module xof_parse_loader
    import kyber_xof_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  ks_valid,
    input  logic [KS_W-1:0]       ks_data,
    output logic                  ks_ready,
    output logic                  parse_start,
    input  logic                  parse_done,
    output logic [B_W-1:0]        B [0:NUM_BYTES-1],
    output logic [BEAT_CNT_W-1:0] beat_cnt,
    output logic                  busy,
    output logic                  done
);

    loader_state_e           state_q;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q;
    logic                    ks_ready_q;
    logic                    parse_start_q;
    logic                    busy_q;
    logic                    done_q;
    logic [B_W-1:0]          b_q [0:NUM_BYTES-1];

    logic                    ks_hs;
    logic                    last_beat;
    logic [B_W-1:0]          lane_b [BEAT_BYTES];

    // ks_ready_q is high exactly while in FILL, so it doubles as the FILL qualifier.
    assign ks_hs     = ks_valid && ks_ready_q;
    assign last_beat = (beat_cnt_q == BEAT_CNT_W'(BEATS - 1));

    // Byte-lane unpack: lane k carries ks_data[8k+7:8k], zero-extended to B_W.
    for (genvar k = 0; k < BEAT_BYTES; k++) begin : g_lane
        assign lane_b[k] = B_W'(ks_data[k*BYTE_W +: BYTE_W]);
    end

    // Control FSM; every output flop is updated on the same edge as its state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= LD_IDLE;
            beat_cnt_q    <= '0;
            ks_ready_q    <= 1'b0;
            parse_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                LD_IDLE, LD_DONE: begin
                    if (req) begin
                        state_q    <= LD_FILL;
                        beat_cnt_q <= '0;
                        ks_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                LD_FILL: begin
                    if (ks_hs) begin
                        beat_cnt_q <= beat_cnt_q + BEAT_CNT_W'(1);
                        if (last_beat) begin
                            state_q       <= LD_START;
                            ks_ready_q    <= 1'b0;
                            parse_start_q <= 1'b1;
                        end
                    end
                end
                LD_START: begin
                    state_q       <= LD_WAIT_PARSE;
                    parse_start_q <= 1'b0;
                end
                LD_WAIT_PARSE: begin
                    if (parse_done) begin
                        state_q <= LD_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= LD_IDLE;
                    beat_cnt_q    <= '0;
                    ks_ready_q    <= 1'b0;
                    parse_start_q <= 1'b0;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b0;
                end
            endcase
        end
    end

    // Buffer B: written only on a FILL handshake, so it is frozen while parse reads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                b_q[i] <= '0;
            end
        end else if (ks_hs) begin
            for (int k = 0; k < BEAT_BYTES; k++) begin
                b_q[b_index(beat_cnt_q, LANE_W'(k))] <= lane_b[k];
            end
        end
    end

    assign ks_ready    = ks_ready_q;
    assign parse_start = parse_start_q;
    assign beat_cnt    = beat_cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign B           = b_q;

endmodule

// File: tb/tb_xof_parse_loader.sv
// Randomised and directed bench for xof_parse_loader against a byte-buffer reference model.
module tb_xof_parse_loader;
    import kyber_xof_pkg::*;

    localparam int PH_IDLE  = 0;
    localparam int PH_FILL  = 1;
    localparam int PH_START = 2;
    localparam int PH_WAIT  = 3;
    localparam int PH_DONE  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic         ks_valid;
    logic [127:0] ks_data;
    logic         ks_ready;
    logic         parse_start;
    logic         parse_done;
    logic [9:0]   b_o [0:767];
    logic [5:0]   beat_cnt;
    logic         busy;
    logic         done;

    xof_parse_loader dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ks_valid    (ks_valid),
        .ks_data     (ks_data),
        .ks_ready    (ks_ready),
        .parse_start (parse_start),
        .parse_done  (parse_done),
        .B           (b_o),
        .beat_cnt    (beat_cnt),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int first_start;

    // Reference model: phase of the load, accepted beat count and the byte buffer.
    int         m_phase;
    int         m_cnt;
    logic [9:0] m_b [768];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [127:0] ramp_beat(input int n);
        logic [127:0] d;
        for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'((n * 16 + k) % 256);
        return d;
    endfunction

    function automatic logic [127:0] rand_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_cnt   = 0;
        for (int i = 0; i < 768; i++) m_b[i] = '0;
    endtask

    // Apply the loader's rules for one clock edge to the model, using the driven inputs.
    task automatic model_edge();
        case (m_phase)
            PH_IDLE, PH_DONE: begin
                if (req) begin
                    m_phase = PH_FILL;
                    m_cnt   = 0;
                end
            end
            PH_FILL: begin
                if (ks_valid) begin
                    for (int k = 0; k < 16; k++) m_b[m_cnt*16 + k] = {2'b00, ks_data[8*k +: 8]};
                    m_cnt++;
                    if (m_cnt == 48) m_phase = PH_START;
                end
            end
            PH_START: m_phase = PH_WAIT;
            PH_WAIT:  if (parse_done) m_phase = PH_DONE;
            default:  m_phase = PH_IDLE;
        endcase
    endtask

    task automatic compare_outputs();
        int nb;
        int nhi;
        nb  = 0;
        nhi = 0;
        check("ks_ready", 32'(ks_ready), 32'(m_phase == PH_FILL));
        check("parse_start", 32'(parse_start), 32'(m_phase == PH_START));
        check("busy", 32'(busy), 32'(m_phase == PH_FILL || m_phase == PH_START || m_phase == PH_WAIT));
        check("done", 32'(done), 32'(m_phase == PH_DONE));
        check("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
        for (int i = 0; i < 768; i++) begin
            if (b_o[i] !== m_b[i]) nb++;
            if (b_o[i][9:8] !== 2'b00) nhi++;
        end
        check("B_entries_wrong", 32'(nb), 32'd0);
        check("B_upper_bits", 32'(nhi), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        compare_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        #1;
        rst = 1'b0;
    endtask

    task automatic check_ramp(input string tag);
        int nbad;
        nbad = 0;
        for (int i = 0; i < 768; i++) if (b_o[i] !== 10'(i % 256)) nbad++;
        check(tag, 32'(nbad), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req        = 1'b0;
        ks_valid   = 1'b0;
        ks_data    = '0;
        parse_done = 1'b0;
        model_reset();
        #2;
        compare_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Ramp stream, ks_valid always high: start pulse in cycle 49.
        cyc = 0; first_start = -1;
        req = 1'b1; ks_valid = 1'b1; ks_data = ramp_beat(0);
        step();
        req = 1'b0;
        for (int t = 0; t < 200 && m_phase != PH_WAIT; t++) begin
            ks_data = ramp_beat(m_cnt);
            step();
            if (parse_start === 1'b1 && first_start < 0) first_start = cyc;
        end
        check("s1_start_cycle", 32'(first_start), 32'd49);
        check("s1_wait_cycle", 32'(cyc), 32'd50);
        check("s1_beat_cnt", 32'(beat_cnt), 32'd48);
        check("s1_B767", 32'(b_o[767]), 32'd255);
        check_ramp("s1_ramp");

        // parse_done three cycles after the start pulse: done one cycle later.
        step(); step();
        parse_done = 1'b1;
        step();
        parse_done = 1'b0;
        check("s1_done_cycle", 32'(cyc), 32'd53);
        check("s1_done", 32'(done), 32'd1);
        check("s1_busy_low", 32'(busy), 32'd0);
        check_ramp("s1_B_held");

        // Same stream with ks_valid toggling 1,0,1,0: start pulse in cycle 96.
        cyc = 0; first_start = -1;
        req = 1'b1; ks_valid = 1'b0; ks_data = ramp_beat(0);
        step();
        req = 1'b0;
        for (int t = 0; t < 300 && m_phase != PH_START; t++) begin
            ks_valid = (cyc % 2 == 1);
            ks_data  = ramp_beat(m_cnt);
            step();
            if (parse_start === 1'b1 && first_start < 0) first_start = cyc;
        end
        check("s2_start_cycle", 32'(first_start), 32'd96);
        check_ramp("s2_ramp");
        // parse_done already high during START must be ignored.
        parse_done = 1'b1;
        step();
        check("s2_done_not_in_start", 32'(done), 32'd0);
        step();
        check("s2_done", 32'(done), 32'd1);
        parse_done = 1'b0;

        // req mid-FILL ignored; req on the last-beat cycle ignored; re-req in DONE.
        req = 1'b1; ks_valid = 1'b1; ks_data = rand_beat();
        step();
        req = 1'b0;
        for (int t = 0; t < 200 && m_phase != PH_WAIT; t++) begin
            ks_data = rand_beat();
            req     = (m_cnt == 20);
            step();
            if (m_cnt == 21 && req) check("s3_cnt_after_req", 32'(beat_cnt), 32'd21);
        end
        req = 1'b0;
        check("s3_wait", 32'(m_phase), 32'(PH_WAIT));
        parse_done = 1'b1;
        step();
        parse_done = 1'b0;
        req = 1'b1;
        step();
        check("s3_redo_done", 32'(done), 32'd0);
        check("s3_redo_cnt", 32'(beat_cnt), 32'd0);
        req = 1'b0;
        for (int t = 0; t < 400 && m_phase != PH_WAIT; t++) begin
            ks_data  = rand_beat();
            ks_valid = ($urandom_range(0, 3) != 0);
            req      = (m_cnt == 47);
            step();
        end
        req = 1'b0;
        check("s3_refill_wait", 32'(m_phase), 32'(PH_WAIT));
        parse_done = 1'b1;
        step();
        parse_done = 1'b0;

        // Asynchronous reset at beat 30, then a clean full load.
        req = 1'b1; ks_valid = 1'b1; ks_data = rand_beat();
        step();
        req = 1'b0;
        for (int t = 0; t < 100 && m_cnt < 30; t++) begin
            ks_data = rand_beat();
            step();
        end
        check("s4_at_beat30", 32'(beat_cnt), 32'd30);
        ks_data = rand_beat();
        do_reset();
        check("s4_cnt_cleared", 32'(beat_cnt), 32'd0);
        req = 1'b1;
        step();
        req = 1'b0;
        for (int t = 0; t < 400 && m_phase != PH_WAIT; t++) begin
            ks_data  = rand_beat();
            ks_valid = ($urandom_range(0, 9) < 7);
            step();
        end
        check("s4_clean_load", 32'(beat_cnt), 32'd48);
        parse_done = 1'b1;
        step();
        parse_done = 1'b0;

        // Free-running random traffic, with occasional resets.
        for (int t = 0; t < 3000; t++) begin
            req        = ($urandom_range(0, 15) == 0);
            ks_valid   = ($urandom_range(0, 1) == 1);
            ks_data    = rand_beat();
            parse_done = ($urandom_range(0, 3) == 0);
            step();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
